// File: rtl/nexusv_pkg.sv
// Shared register offsets, FSM state type and decode helper for the nexusv CLINT.
package nexusv_pkg;

    localparam logic [15:0] CLINT_MSIP_OFF        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO_OFF = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI_OFF = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO_OFF    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI_OFF    = 16'hBFFC;

    typedef enum logic [0:0] {
        StIdle,
        StAck
    } clint_state_e;

    // Byte offset of the addressed word; the byte-lane bits are dropped.
    function automatic logic [15:0] clint_word_off(input logic [13:0] word_idx);
        return {word_idx, 2'b00};
    endfunction

endpackage

// File: rtl/nexusv_clint_timebase.sv
// Prescaler plus 64-bit mtime counter with independent full-word write ports per half.
module nexusv_clint_timebase #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lo_we_i,
    input  logic        hi_we_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] mtime_o
);

    localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PreW-1:0] prescale_q, prescale_d;
    logic [63:0]     mtime_q, mtime_d;
    logic            tick;

    assign tick = (prescale_q == PreW'(TICK_DIV - 1));

    always_comb begin
        prescale_d = tick ? '0 : prescale_q + PreW'(1);
    end

    // A software write replaces its half and freezes the other half for that edge,
    // so a coincident tick never carries into or out of the written word.
    always_comb begin
        mtime_d = mtime_q;
        if (lo_we_i || hi_we_i) begin
            if (lo_we_i) begin
                mtime_d[31:0] = wdata_i;
            end
            if (hi_we_i) begin
                mtime_d[63:32] = wdata_i;
            end
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_q <= '0;
            mtime_q    <= '0;
        end else begin
            prescale_q <= prescale_d;
            mtime_q    <= mtime_d;
        end
    end

    assign mtime_o = mtime_q;

endmodule

// File: rtl/nexusv_clint.sv
// Core-local interruptor: msip, mtimecmp and mtime behind a two-state acknowledge FSM.
// Optional tear-free mtime read via shadow register: NEXUSV_CLINT_MTIME_SNAPSHOT_EN.
module nexusv_clint
    import nexusv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_write,
    input  logic        bus_valid,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    output logic        mtip,
    output logic        msip
);

    clint_state_e state_q, state_d;
    logic [31:0]  rdata_q, rdata_d;
    logic [63:0]  mtimecmp_q, mtimecmp_d;
    logic         msip_q, msip_d;
    logic         mtip_q;

    logic [63:0]  mtime;
    logic [31:0]  mtime_hi_rd;
    logic [15:0]  off;
    logic [31:0]  rd_data;
    logic         hit, accept, wr_en, rd_en;
    logic         mt_lo_we, mt_hi_we;
    logic         unused_addr;

    assign unused_addr = ^bus_addr[1:0];
    assign off         = clint_word_off(bus_addr[15:2]);
    assign hit         = bus_valid && (bus_addr[31:16] == BASE_ADDR[31:16]);
    assign accept      = (state_q == StIdle) && hit;
    assign wr_en       = accept && bus_write;
    assign rd_en       = accept && !bus_write;
    assign mt_lo_we    = wr_en && (off == CLINT_MTIME_LO_OFF);
    assign mt_hi_we    = wr_en && (off == CLINT_MTIME_HI_OFF);

    nexusv_clint_timebase #(
        .TICK_DIV(TICK_DIV)
    ) u_timebase (
        .clk    (clk),
        .rst    (rst),
        .lo_we_i(mt_lo_we),
        .hi_we_i(mt_hi_we),
        .wdata_i(bus_wdata),
        .mtime_o(mtime)
    );

`ifdef NEXUSV_CLINT_MTIME_SNAPSHOT_EN
    logic [31:0] shadow_q, shadow_d;

    // Reading the low word freezes the high word so a following high read cannot tear.
    always_comb begin
        shadow_d = shadow_q;
        if (rd_en && (off == CLINT_MTIME_LO_OFF)) begin
            shadow_d = mtime[63:32];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign mtime_hi_rd = shadow_q;
`else
    assign mtime_hi_rd = mtime[63:32];
`endif

    always_comb begin
        rd_data = '0;
        case (off)
            CLINT_MSIP_OFF:        rd_data = {31'b0, msip_q};
            CLINT_MTIMECMP_LO_OFF: rd_data = mtimecmp_q[31:0];
            CLINT_MTIMECMP_HI_OFF: rd_data = mtimecmp_q[63:32];
            CLINT_MTIME_LO_OFF:    rd_data = mtime[31:0];
            CLINT_MTIME_HI_OFF:    rd_data = mtime_hi_rd;
            default:               rd_data = '0;
        endcase
    end

    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        if (wr_en) begin
            case (off)
                CLINT_MSIP_OFF:        msip_d             = bus_wdata[0];
                CLINT_MTIMECMP_LO_OFF: mtimecmp_d[31:0]  = bus_wdata;
                CLINT_MTIMECMP_HI_OFF: mtimecmp_d[63:32] = bus_wdata;
                default:               ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = '0;
        case (state_q)
            StIdle: begin
                if (hit) begin
                    state_d = StAck;
                    if (!bus_write) begin
                        rdata_d = rd_data;
                    end
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            rdata_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            mtip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            mtip_q     <= (mtime >= mtimecmp_q);
        end
    end

    assign bus_ready = (state_q == StAck);
    assign bus_rdata = rdata_q;
    assign mtip      = mtip_q;
    assign msip      = msip_q;

endmodule

// File: tb/tb_nexusv_clint.sv
// Bench for nexusv_clint: one instance with TICK_DIV=1, one with TICK_DIV=4, shared bus.
module tb_nexusv_clint;

    localparam logic [31:0] A_MSIP   = 32'h0200_0000;
    localparam logic [31:0] A_CMP_LO = 32'h0200_4000;
    localparam logic [31:0] A_CMP_HI = 32'h0200_4004;
    localparam logic [31:0] A_MT_LO  = 32'h0200_BFF8;
    localparam logic [31:0] A_MT_HI  = 32'h0200_BFFC;
`ifdef NEXUSV_CLINT_MTIME_SNAPSHOT_EN
    localparam bit Snap = 1'b1;
`else
    localparam bit Snap = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst1, rst4;
    logic        sel;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_write, bus_valid;
    logic        valid1, valid4, ready1, ready4, mtip1, mtip4, msip1, msip4;
    logic [31:0] rdata1, rdata4;
    logic        ready_m;
    logic [31:0] rdata_m;

    int checks = 0;
    int errors = 0;
    int cyc4   = 0;
    int rise4  = 0;

    typedef struct {
        bit          chk;
        logic [31:0] exp;
        string       nm;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        logic [31:0] wdata;
        bit          chk;
        logic [31:0] exp;
        bit          mchk;
        bit          mexp;
        string       nm;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    assign valid1  = bus_valid & ~sel;
    assign valid4  = bus_valid & sel;
    assign ready_m = sel ? ready4 : ready1;
    assign rdata_m = sel ? rdata4 : rdata1;

    nexusv_clint #(.TICK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst1), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_write(bus_write), .bus_valid(valid1), .bus_rdata(rdata1),
        .bus_ready(ready1), .mtip(mtip1), .msip(msip1)
    );

    nexusv_clint #(.TICK_DIV(4)) u_dut4 (
        .clk(clk), .rst(rst4), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_write(bus_write), .bus_valid(valid4), .bus_rdata(rdata4),
        .bus_ready(ready4), .mtip(mtip4), .msip(msip4)
    );

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard consumer: every acknowledge pops the oldest expectation.
    always @(negedge clk) begin
        sb_t e;
        if (ready_m) begin
            if (sb_q.size() == 0) begin
                chk32("unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                if (e.chk) chk32(e.nm, rdata_m, e.exp);
            end
        end
    end

    always @(posedge clk or posedge rst4) begin
        if (rst4) cyc4 <= 0;
        else      cyc4 <= cyc4 + 1;
    end

    always @(negedge clk) begin
        if (!rst4 && mtip4 && rise4 == 0) rise4 = cyc4;
    end

    task automatic access(input bit s, input logic [31:0] a, input bit w, input logic [31:0] d,
                          input bit chk, input logic [31:0] exp, input string nm);
        int n;
        @(negedge clk);
        sb_q.push_back('{chk, exp, nm});
        sel       = s;
        bus_addr  = a;
        bus_write = w;
        bus_wdata = d;
        bus_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready_m && n < 10);
        if (!ready_m) begin
            void'(sb_q.pop_front());
            chk32({nm, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk32({nm, "_latency"}, 32'(n), 32'd1);
        end
        bus_valid = 1'b0;
    endtask

    function automatic vec_t mk(input logic [31:0] a, input bit w, input logic [31:0] d,
                                input bit c, input logic [31:0] e, input bit mc, input bit me,
                                input string nm);
        vec_t v;
        v = '{a, w, d, c, e, mc, me, nm};
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nrdy;
        int nrd;
        rst1 = 1'b1; rst4 = 1'b1; sel = 1'b0; bus_valid = 1'b0;
        bus_addr = '0; bus_wdata = '0; bus_write = 1'b0;

        tbl.push_back(mk(A_CMP_LO, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, "cmp_lo_rst"));
        tbl.push_back(mk(A_CMP_HI, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, "cmp_hi_rst"));
        tbl.push_back(mk(A_MSIP, 0, 0, 1, 32'h0, 1, 0, "msip_rst"));
        tbl.push_back(mk(A_MSIP, 1, 32'h1, 0, 0, 1, 1, "msip_set"));
        tbl.push_back(mk(A_MSIP, 0, 0, 1, 32'h1, 1, 1, "msip_rd1"));
        tbl.push_back(mk(A_MSIP, 1, 32'h0, 0, 0, 1, 0, "msip_clr"));
        tbl.push_back(mk(A_MSIP, 0, 0, 1, 32'h0, 1, 0, "msip_rd0"));
        tbl.push_back(mk(A_MSIP, 1, 32'hFFFF_FFFE, 0, 0, 1, 0, "msip_bit0"));
        tbl.push_back(mk(A_MSIP, 1, 32'hFFFF_FFFF, 0, 0, 1, 1, "msip_all1"));
        tbl.push_back(mk(A_MSIP, 0, 0, 1, 32'h1, 1, 1, "msip_upper0"));
        tbl.push_back(mk(A_MSIP, 1, 32'h0, 0, 0, 1, 0, "msip_clr2"));
        tbl.push_back(mk(A_CMP_LO, 1, 32'h1234_5678, 0, 0, 0, 0, "cmp_lo_wr"));
        tbl.push_back(mk(A_CMP_LO, 0, 0, 1, 32'h1234_5678, 0, 0, "cmp_lo_rd"));
        tbl.push_back(mk(32'h0200_4007, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, "cmp_hi_keep"));
        tbl.push_back(mk(A_CMP_HI, 1, 32'hABCD_0000, 0, 0, 0, 0, "cmp_hi_wr"));
        tbl.push_back(mk(A_CMP_HI, 0, 0, 1, 32'hABCD_0000, 0, 0, "cmp_hi_rd"));
        tbl.push_back(mk(A_CMP_LO, 0, 0, 1, 32'h1234_5678, 0, 0, "cmp_lo_keep"));
        tbl.push_back(mk(A_CMP_HI, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, "cmp_hi_restore"));
        tbl.push_back(mk(32'h0200_1234, 0, 0, 1, 32'h0, 0, 0, "unmapped_rd"));
        tbl.push_back(mk(32'h0200_1234, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, "unmapped_wr"));
        tbl.push_back(mk(32'h0200_1236, 0, 0, 1, 32'h0, 0, 0, "unmapped_rd2"));

        repeat (3) @(negedge clk);
        rst1 = 1'b0; rst4 = 1'b0;

        chk32("rst_ready1", 32'(ready1), 32'd0);
        chk32("rst_rdata1", rdata1, 32'd0);
        chk32("rst_mtip1", 32'(mtip1), 32'd0);
        chk32("rst_msip1", 32'(msip1), 32'd0);
        chk32("rst_ready4", 32'(ready4), 32'd0);
        chk32("rst_mtip4", 32'(mtip4), 32'd0);

        // Timer instance: mtimecmp = 20, high half first.
        access(1, A_CMP_HI, 1, 32'h0, 0, 0, "t4_cmp_hi");
        access(1, A_CMP_LO, 1, 32'd20, 0, 0, "t4_cmp_lo");

        foreach (tbl[i]) begin
            access(0, tbl[i].addr, tbl[i].wr, tbl[i].wdata, tbl[i].chk, tbl[i].exp, tbl[i].nm);
            if (tbl[i].mchk) chk32({tbl[i].nm, "_msip"}, 32'(msip1), 32'(tbl[i].mexp));
        end

        // Carry from low into high word, then tear-free (or live) high read.
        access(0, A_MT_HI, 1, 32'h0, 0, 0, "mt_hi0");
        access(0, A_MT_LO, 1, 32'hFFFF_FFF0, 0, 0, "mt_lo_f0");
        access(0, A_MT_LO, 0, 0, 1, 32'hFFFF_FFF1, "mtime_lo_rd");
        repeat (30) @(negedge clk);
        access(0, A_MT_HI, 0, 0, 1, Snap ? 32'h0 : 32'h1, "mtime_hi_carry");

        // Full 64-bit wrap.
        access(0, A_MT_HI, 1, 32'hFFFF_FFFF, 0, 0, "mt_hi_ff");
        access(0, A_MT_LO, 1, 32'hFFFF_FFFE, 0, 0, "mt_lo_fe");
        access(0, A_MT_LO, 0, 0, 1, 32'hFFFF_FFFF, "mtime_lo_pre");
        access(0, A_MT_HI, 0, 0, 1, Snap ? 32'hFFFF_FFFF : 32'h0, "mtime_hi_wrap");
        access(0, A_MT_LO, 0, 0, 1, 32'd3, "mtime_lo_wrap");

        // Out-of-window access is never acknowledged.
        @(negedge clk);
        sel = 1'b0; bus_addr = 32'h0300_0000; bus_write = 1'b0; bus_valid = 1'b1;
        nrdy = 0; nrd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready1) nrdy++;
            if (rdata1 != 0) nrd++;
        end
        bus_valid = 1'b0;
        chk32("miss_no_ready", 32'(nrdy), 32'd0);
        chk32("miss_rdata0", 32'(nrd), 32'd0);

        // mtime reaches 20 after edge 80; mtip registers it one edge later.
        for (int i = 0; i < 300 && cyc4 < 90; i++) @(negedge clk);
        chk32("mtip_rise_cycle", 32'(rise4), 32'd81);
        chk32("mtip_high", 32'(mtip4), 32'd1);
        access(1, A_CMP_LO, 1, 32'd1000, 0, 0, "t4_cmp_1000");
        chk32("mtip_hold", 32'(mtip4), 32'd1);
        @(negedge clk);
        chk32("mtip_clear", 32'(mtip4), 32'd0);

        // Reset during the acknowledge cycle aborts the transaction.
        @(negedge clk);
        sel = 1'b0; bus_addr = A_MSIP; bus_write = 1'b1; bus_wdata = 32'h1; bus_valid = 1'b1;
        @(posedge clk);
        #1;
        chk32("pre_rst_ready", 32'(ready1), 32'd1);
        #1 rst1 = 1'b1;
        #1;
        chk32("rst_drop_ready", 32'(ready1), 32'd0);
        chk32("rst_msip_lost", 32'(msip1), 32'd0);
        bus_valid = 1'b0;
        @(negedge clk);
        rst1 = 1'b0;
        access(0, A_MSIP, 0, 0, 1, 32'h0, "post_rst_msip");
        access(0, A_CMP_LO, 0, 0, 1, 32'hFFFF_FFFF, "post_rst_cmp");

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
